// File: rtl/button_event_pkg.sv
// Shared io event definitions: the gesture FSM state encoding and the
// timer-threshold range check used by the io event blocks.
package button_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } btn_state_e;

  // A tick threshold is usable when it is at least 2 and its terminal
  // value (ticks-1) still fits in a timer of cnt_width bits.
  function automatic bit ticks_in_range(input int ticks, input int cnt_width);
    longint unsigned max_ticks;
    max_ticks = longint'(1) << cnt_width;
    return (ticks >= 2) && (longint'(ticks) <= max_ticks);
  endfunction

endpackage

// File: rtl/button_event_edge_detect.sv
// edge_detect: registers a synchronous level and flags the edges.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_level        : level input, already synchronous to i_clk
//   o_rise         : level went to p_ACTIVE_LEVEL this cycle (combinational)
//   o_fall         : level left p_ACTIVE_LEVEL this cycle (combinational)
//   o_prev         : registered level (inactive while in reset)
module edge_detect
  import button_event_pkg::*;
#(
  parameter logic p_ACTIVE_LEVEL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_prev
);

  logic prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= ~p_ACTIVE_LEVEL;
    end else begin
      prev_q <= i_level;
    end
  end

  assign o_rise = (i_level == p_ACTIVE_LEVEL) && (prev_q != p_ACTIVE_LEVEL);
  assign o_fall = (i_level != p_ACTIVE_LEVEL) && (prev_q == p_ACTIVE_LEVEL);
  assign o_prev = prev_q;

endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release edges
// and click / double-click / long-press gestures.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_level        : debounced level, synchronous to i_clk
//   o_press        : 1-cycle pulse on a press edge
//   o_release      : 1-cycle pulse on a release edge
//   o_click        : 1-cycle pulse when a single click is confirmed
//   o_double       : 1-cycle pulse on the release ending a double click
//   o_long         : 1-cycle pulse when a press reaches p_LONG_TICKS
//   o_held         : high while the button is pressed
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no gesture in progress
// ST_PRESS1 | first press held, counting toward long press
// ST_WAIT2  | released after a short press, waiting for a second press
// ST_PRESS2 | second press held; release gives a double click
// ST_LONG   | long press reported, waiting for release
module button_event
  import button_event_pkg::*;
#(
  parameter int   p_CNT_WIDTH    = 4,
  parameter int   p_LONG_TICKS   = 8,
  parameter int   p_DCLICK_TICKS = 6,
  parameter logic p_ACTIVE_LEVEL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_double,
  output logic o_long,
  output logic o_held
);

  if (!ticks_in_range(p_LONG_TICKS, p_CNT_WIDTH)) begin : g_bad_long_ticks
    $error("button_event: p_LONG_TICKS must be in [2, 2**p_CNT_WIDTH]");
  end
  if (!ticks_in_range(p_DCLICK_TICKS, p_CNT_WIDTH)) begin : g_bad_dclick_ticks
    $error("button_event: p_DCLICK_TICKS must be in [2, 2**p_CNT_WIDTH]");
  end

  localparam logic [p_CNT_WIDTH-1:0] LongLast   = p_CNT_WIDTH'(p_LONG_TICKS - 1);
  localparam logic [p_CNT_WIDTH-1:0] DclickLast = p_CNT_WIDTH'(p_DCLICK_TICKS - 1);

  logic rise, fall, prev;

  edge_detect #(
    .p_ACTIVE_LEVEL(p_ACTIVE_LEVEL)
  ) u_edge (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_level(i_level),
    .o_rise (rise),
    .o_fall (fall),
    .o_prev (prev)
  );

  btn_state_e             state_q, state_d;
  logic [p_CNT_WIDTH-1:0] timer_q, timer_d;
  logic press_q, release_q, click_q, double_q, long_q;
  logic click_d, double_d, long_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      press_q   <= rise;
      release_q <= fall;
      click_q   <= click_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  // Edges are tested before timeouts so that a press on the WAIT2 timeout
  // cycle, or a release on the long threshold cycle, takes priority.
  always_comb begin
    state_d  = state_q;
    click_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    timer_d  = (timer_q == '1) ? timer_q : timer_q + p_CNT_WIDTH'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_WAIT2;
        end else if (timer_q == LongLast) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_WAIT2: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (timer_q == DclickLast) begin
          click_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (timer_q == LongLast) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_LONG: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_double  = double_q;
  assign o_long    = long_q;
  assign o_held    = (prev == p_ACTIVE_LEVEL);

endmodule

// File: tb/tb_button_event.sv
module tb_button_event;

  localparam int L = 8;
  localparam int D = 6;

  logic clk, rst_n, i_level;
  logic o_press, o_release, o_click, o_double, o_long, o_held;

  button_event #(
    .p_CNT_WIDTH   (4),
    .p_LONG_TICKS  (L),
    .p_DCLICK_TICKS(D),
    .p_ACTIVE_LEVEL(1'b1)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_level  (i_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_click  (o_click),
    .o_double (o_double),
    .o_long   (o_long),
    .o_held   (o_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Gesture model: timestamps of the current press / release and deadline
  // arithmetic against them. Expected outputs refer to the cycle after the edge.
  int  cyc = 0;
  bit  m_prev = 0;
  int  npress = 0;
  bit  is_long = 0;
  int  t_p = 0, t_r = 0;
  bit  e_press, e_release, e_click, e_double, e_long, e_held;
  bit  rise, fall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 0; npress = 0; is_long = 0;
      {e_press, e_release, e_click, e_double, e_long, e_held} = '0;
    end else begin
      cyc++;
      rise = i_level && !m_prev;
      fall = !i_level && m_prev;
      {e_click, e_double, e_long} = '0;
      e_press   = rise;
      e_release = fall;
      if (fall) begin
        if (is_long) begin
          npress = 0; is_long = 0;
        end else if (npress == 2) begin
          e_double = 1; npress = 0;
        end else if (npress == 1) begin
          t_r = cyc;
        end
      end else if (rise) begin
        npress = npress + 1;
        t_p = cyc;
      end else if (m_prev && !is_long && npress > 0 && cyc - t_p == L) begin
        e_long = 1; is_long = 1;
      end else if (!m_prev && npress == 1 && cyc - t_r == D) begin
        e_click = 1; npress = 0;
      end
      m_prev = i_level;
      e_held = i_level;
    end
  end

  // Per-cycle compare plus pulse bookkeeping for the directed checks.
  int tcyc = 0;
  int n_press = 0, n_release = 0, n_click = 0, n_double = 0, n_long = 0;
  int t_press_o = 0, t_release_o = 0, t_click_o = 0, t_double_o = 0, t_long_o = 0;
  logic [5:0] act_v, exp_v;

  always @(negedge clk) begin
    tcyc++;
    act_v = {o_press, o_release, o_click, o_double, o_long, o_held};
    exp_v = {e_press, e_release, e_click, e_double, e_long, e_held};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle_compare t=%0t got press/rel/click/dbl/long/held=%b expected %b",
               $time, act_v, exp_v);
    end
    if (o_press)   begin n_press++;   t_press_o   = tcyc; end
    if (o_release) begin n_release++; t_release_o = tcyc; end
    if (o_click)   begin n_click++;   t_click_o   = tcyc; end
    if (o_double)  begin n_double++;  t_double_o  = tcyc; end
    if (o_long)    begin n_long++;    t_long_o    = tcyc; end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    i_level = lvl;
    repeat (n) @(negedge clk);
  endtask

  int b_press, b_release, b_click, b_double, b_long;
  task automatic snap();
    b_press = n_press; b_release = n_release; b_click = n_click;
    b_double = n_double; b_long = n_long;
  endtask

  initial begin
    i_level = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({o_press, o_release, o_click, o_double, o_long, o_held}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single click
    snap();
    hold(1, 3); hold(0, 12);
    chk("single_press_cnt",   n_press - b_press, 1);
    chk("single_release_cnt", n_release - b_release, 1);
    chk("single_click_cnt",   n_click - b_click, 1);
    chk("single_click_delay", t_click_o - t_release_o, 6);
    chk("single_no_double",   n_double - b_double, 0);
    chk("single_no_long",     n_long - b_long, 0);

    // double click
    snap();
    hold(1, 3); hold(0, 2); hold(1, 3); hold(0, 12);
    chk("double_press_cnt",  n_press - b_press, 2);
    chk("double_double_cnt", n_double - b_double, 1);
    chk("double_with_rel",   t_double_o - t_release_o, 0);
    chk("double_no_click",   n_click - b_click, 0);

    // long press
    snap();
    hold(1, 20);
    chk("long_cnt",   n_long - b_long, 1);
    chk("long_delay", t_long_o - t_press_o, 8);
    hold(0, 12);
    chk("long_release_cnt", n_release - b_release, 1);
    chk("long_no_click",    n_click - b_click, 0);
    chk("long_no_double",   n_double - b_double, 0);

    // release exactly on the long threshold: release wins, becomes a click
    snap();
    hold(1, 8); hold(0, 12);
    chk("thresh_no_long",   n_long - b_long, 0);
    chk("thresh_click_cnt", n_click - b_click, 1);

    // one cycle past the threshold: long
    snap();
    hold(1, 9); hold(0, 12);
    chk("thresh9_long_cnt", n_long - b_long, 1);
    chk("thresh9_no_click", n_click - b_click, 0);

    // second press exactly on the WAIT2 timeout cycle
    snap();
    hold(1, 3); hold(0, 6); hold(1, 3); hold(0, 12);
    chk("boundary_no_click", n_click - b_click, 0);
    chk("boundary_double",   n_double - b_double, 1);
    chk("boundary_presses",  n_press - b_press, 2);

    // gap one longer than the window: click, then a fresh gesture
    snap();
    hold(1, 3); hold(0, 7); hold(1, 3); hold(0, 12);
    chk("late_click_cnt", n_click - b_click, 2);
    chk("late_no_double", n_double - b_double, 0);

    // reset while in WAIT2, during the o_release pulse
    snap();
    hold(1, 3);
    i_level = 1'b0;
    @(posedge clk); #2;
    chk("release_before_reset", int'(o_release), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", int'({o_press, o_release, o_click, o_double, o_long, o_held}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    hold(0, 12);
    chk("reset_no_click",  n_click - b_click, 0);
    chk("reset_no_double", n_double - b_double, 0);
    chk("reset_no_long",   n_long - b_long, 0);

    // button held while reset releases
    rst_n = 1'b0;
    i_level = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    rst_n = 1'b1;
    hold(1, 15);
    chk("heldrst_press_cnt",  n_press - b_press, 1);
    chk("heldrst_long_cnt",   n_long - b_long, 1);
    chk("heldrst_long_delay", t_long_o - t_press_o, 8);
    hold(0, 12);
    chk("heldrst_no_click", n_click - b_click, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 The block SHALL have parameter p_CNT_WIDTH, default 4: width of the internal event timer.
REQ-002 The block SHALL have parameter p_LONG_TICKS, default 8: cycles a press must last to count as long.
REQ-003 The block SHALL have parameter p_DCLICK_TICKS, default 6: maximum release-to-press gap, in cycles, for a double click.
REQ-004 The block SHALL have parameter p_ACTIVE_LEVEL, default 1'b1: the i_level value that means "pressed".
REQ-005 i_clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 i_rst_n, input, 1: reset; asynchronous, active-low.
REQ-007 i_level, input, 1: debounced button level, already synchronous to i_clk; no resynchronisation inside the block.
REQ-008 o_press, output, 1: one-cycle pulse on a press edge.
REQ-009 o_release, output, 1: one-cycle pulse on a release edge.
REQ-010 o_click, output, 1: one-cycle pulse for a confirmed single click.
REQ-011 o_double, output, 1: one-cycle pulse for a double click.
REQ-012 o_long, output, 1: one-cycle pulse when a long press is detected.
REQ-013 o_held, output, 1: level output, high while the button is pressed.

Function
REQ-014 Edge detection SHALL register i_level into r_prev.
- Press edge: i_level==active and r_prev==inactive.
- Release edge: the opposite.
REQ-015 All outputs SHALL be registered: each pulse is high exactly one cycle, in the cycle after the sampling edge that detected the event.
REQ-016 o_held SHALL equal r_prev mapped to active-high.
REQ-017 The FSM SHALL have the states IDLE, PRESS1, WAIT2, PRESS2 and LONG.
REQ-018 The timer SHALL clear to 0 on every state entry, increment once per cycle, and saturate at all-ones.
REQ-019 IDLE: a press edge -> PRESS1.
REQ-020 PRESS1:
- Release edge -> WAIT2.
- Timer==p_LONG_TICKS-1 with no release -> o_long, then LONG.
REQ-021 LONG: release edge -> IDLE; o_click and o_double are not generated.
REQ-022 WAIT2:
- Press edge -> PRESS2.
- Timer==p_DCLICK_TICKS-1 with no press -> o_click, then IDLE.
REQ-023 PRESS2:
- Release edge -> o_double, then IDLE.
- Timer==p_LONG_TICKS-1 -> o_long, then LONG; the pending click is discarded.
REQ-024 Timing: o_long SHALL pulse exactly p_LONG_TICKS cycles after the o_press pulse that started the press.
REQ-025 Timing: o_click SHALL pulse exactly p_DCLICK_TICKS cycles after the o_release pulse.
REQ-026 Simultaneous events:
- Timeout and a press edge in the same WAIT2 cycle: the press wins (PRESS2, no o_click).
- Long threshold and a release in the same PRESS cycle: the release wins.
REQ-027 o_press and o_release SHALL fire on every edge regardless of FSM state.
REQ-028 Parameter rules:
- 2 <= p_LONG_TICKS <= 2**p_CNT_WIDTH.
- 2 <= p_DCLICK_TICKS <= 2**p_CNT_WIDTH.
- A violation SHALL stop elaboration with an error.

Reset
REQ-029 While i_rst_n is low:
- All outputs are 0, the state is IDLE, the timer is 0.
- r_prev holds the inactive level.
REQ-030 Reset asserted mid-operation SHALL abort any pending click, double or long event with no pulse.
REQ-031 If i_level is active when reset releases, the block SHALL generate o_press one cycle after the first sampling edge, then behave normally.

Structure
REQ-032 The state encoding and the timer-threshold width checks SHALL live in a shared io definitions header, for reuse by other io event blocks.
REQ-033 Edge detection SHALL be a separate sub-module, edge_detect.
- Inputs: clock, reset, level.
- Outputs: rise, fall, prev.
- It is reusable after the Debouncer elsewhere.
REQ-034 The block SHALL add no more than one cycle of latency on top of edge_detect.

Verification (p_CNT_WIDTH=4, p_LONG_TICKS=8, p_DCLICK_TICKS=6, active-high)
REQ-035 Single click: press for 3 cycles, then release.
- o_press, then o_release.
- o_click exactly 6 cycles after o_release.
- No o_double, no o_long.
REQ-036 Double click: press 3, release 2, press 3, release.
- Two o_press pulses.
- o_double one cycle after the second release edge.
- No o_click.
REQ-037 Long press: hold for 20 cycles.
- o_long exactly 8 cycles after o_press.
- On release: o_release only, no o_click.
REQ-038 Press on timeout boundary: second press edge exactly on the WAIT2 timeout cycle.
- PRESS2 entered; o_click never pulses.
REQ-039 Reset mid-WAIT2: assert i_rst_n low for 2 cycles.
- All outputs 0 immediately (asynchronous).
- No o_click after reset releases.
REQ-040 Held through reset: i_level high when i_rst_n deasserts.
- o_press pulses once.
- o_long 8 cycles later.
